// File: rtl/da2_sample_scheduler_if.sv
// Requester-side handshake bundle for the DA2 sample scheduler: one valid/ready/data
// channel per DAC output (A and B).
interface da2_sample_scheduler_if;
  logic        a_valid;
  logic [11:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [11:0] b_data;
  logic        b_ready;

  modport master (output a_valid, a_data, b_valid, b_data, input a_ready, b_ready);
  modport slave  (input a_valid, a_data, b_valid, b_data, output a_ready, b_ready);
endinterface

// File: rtl/da2_sample_scheduler.sv
// Fixed-rate sample scheduler and dual-channel serial sequencer for the Pmod DA2 DAC.
// Optional DA2_POWERDOWN_EN adds pd_mode[1:0], sent in frame bits 13:12.
module da2_sample_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RATE_W     = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_div,
`ifdef DA2_POWERDOWN_EN
  input  logic [1:0]        pd_mode,
`endif
  da2_sample_scheduler_if.slave req,
  output logic              da2_CS,
  output logic              da2_SCLK,
  output logic              da2_DINA,
  output logic              da2_DINB,
  output logic              busy,
  output logic              a_underrun,
  output logic              b_underrun,
  output logic              tick_miss
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state_q;
  logic [RATE_W-1:0] cnt_q;
  logic              tick_c;
  logic              load_c;
  logic [4:0]        cyc_q;
  logic              cs_q, sclk_q, busy_q, miss_q;
  logic [1:0]        din_q, urun_q;
  logic [15:0]       sr_q    [2];
  logic [11:0]       hold_q  [2];

  logic [11:0]       mem_q   [2][FIFO_DEPTH];
  logic [AW-1:0]     wptr_q  [2];
  logic [AW-1:0]     rptr_q  [2];
  logic [CW-1:0]     count_q [2];
  logic [CW-1:0]     count_d [2];
  logic [1:0]        ready_q;
  logic [1:0]        push_c, pop_c;
  logic [11:0]       wdata_c [2];
  logic [11:0]       head_c  [2];
  logic [15:0]       frame_c [2];

  // Sample-period counter: tick on reaching rate_div, then reload to 0
  always_comb begin
    tick_c = enable && (cnt_q >= rate_div);
    load_c = tick_c && (state_q == IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                 cnt_q <= '0;
    else if (!enable || tick_c)   cnt_q <= '0;
    else                          cnt_q <= cnt_q + RATE_W'(1);
  end

  always_comb begin
    push_c[0]  = req.a_valid && ready_q[0];
    push_c[1]  = req.b_valid && ready_q[1];
    wdata_c[0] = req.a_data;
    wdata_c[1] = req.b_data;
    for (int i = 0; i < 2; i++) begin
      pop_c[i]   = load_c && (count_q[i] != '0);
      head_c[i]  = mem_q[i][rptr_q[i]];
      count_d[i] = count_q[i] + CW'(push_c[i]) - CW'(pop_c[i]);
`ifdef DA2_POWERDOWN_EN
      frame_c[i] = {2'b00, pd_mode, pop_c[i] ? head_c[i] : hold_q[i]};
`else
      frame_c[i] = {4'b0000, pop_c[i] ? head_c[i] : hold_q[i]};
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 2; i++)
      if (push_c[i]) mem_q[i][wptr_q[i]] <= wdata_c[i];
  end

  // FIFO bookkeeping; ready tracks next occupancy so a full FIFO never over-accepts
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ready_q <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_c[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop_c[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
        count_q[i] <= count_d[i];
        ready_q[i] <= (count_d[i] != CW'(FIFO_DEPTH));
      end
    end
  end

  // Frame sequencer: 32 cycles of CS low (16 SCLK periods) then a 2-cycle CS-high gap
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= '0;
      busy_q  <= 1'b0;
      miss_q  <= 1'b0;
      urun_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        sr_q[i]   <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      urun_q <= '0;
      miss_q <= tick_c && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            for (int i = 0; i < 2; i++) begin
              if (pop_c[i]) hold_q[i] <= head_c[i];
              else          urun_q[i] <= 1'b1;
              sr_q[i]  <= frame_c[i];
              din_q[i] <= frame_c[i][15];
            end
            cs_q    <= 1'b0;
            sclk_q  <= 1'b1;
            cyc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cyc_q <= cyc_q + 5'd1;
          if (!cyc_q[0]) begin
            sclk_q <= 1'b0;
          end else if (cyc_q == 5'd31) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= '0;
            cyc_q   <= '0;
            state_q <= GAP;
          end else begin
            sclk_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
              sr_q[i]  <= {sr_q[i][14:0], 1'b0};
              din_q[i] <= sr_q[i][14];
            end
          end
        end
        GAP: begin
          if (cyc_q == 5'd1) begin
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cyc_q <= cyc_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.a_ready = ready_q[0];
  assign req.b_ready = ready_q[1];
  assign da2_CS      = cs_q;
  assign da2_SCLK    = sclk_q;
  assign da2_DINA    = din_q[0];
  assign da2_DINB    = din_q[1];
  assign busy        = busy_q;
  assign a_underrun  = urun_q[0];
  assign b_underrun  = urun_q[1];
  assign tick_miss   = miss_q;

endmodule

// File: doc/da2_sample_scheduler.md
Name: da2_sample_scheduler

Overview:
Sample-rate scheduler and serial sequencer for the two-channel 12-bit DA2 DAC.
- Buffers samples for channels A and B in per-channel FIFOs, fed by two independent valid/ready requesters.
- Pops one sample pair per programmable sample-period tick and shifts both channels out simultaneously on CS/SCLK/DINA/DINB.
- Sits between the AHB-Lite register/DMA logic and the Pmod DA2 pins; replaces free-running, change-triggered writes with a fixed sample rate.

Parameters:
FIFO_DEPTH, 4, entries per channel FIFO; power of 2, minimum 2.
RATE_W, 16, width of the rate_div input and the period counter.

Ports:
HCLK  in  1  system clock, 50 MHz.
HRESETn  in  1  reset, asynchronous, active-low.
enable  in  1  1 = generate sample ticks; 0 = period counter held at 0.
rate_div  in  RATE_W  sample period minus 1, in HCLK cycles; legal range is >= 34.
a_valid  in  1  channel A sample offered.
a_data  in  12  channel A sample.
a_ready  out  1  channel A FIFO not full.
b_valid  in  1  channel B sample offered.
b_data  in  12  channel B sample.
b_ready  out  1  channel B FIFO not full.
da2_CS  out  1  DAC SYNC, active-low.
da2_SCLK  out  1  serial clock, HCLK/2 during a frame, idles high.
da2_DINA  out  1  channel A serial data.
da2_DINB  out  1  channel B serial data.
busy  out  1  frame or inter-frame gap in progress.
a_underrun  out  1  1-cycle pulse: tick found FIFO A empty.
b_underrun  out  1  1-cycle pulse: tick found FIFO B empty.
tick_miss  out  1  1-cycle pulse: tick arrived while busy.

Behaviour:
- Reset (async, HRESETn=0):
  - Outputs: da2_CS=1, da2_SCLK=1, DINA=DINB=0, busy=0, all pulse outputs 0.
  - Internal: FIFOs empty (a_ready=b_ready=1), held samples 0, period counter 0, state IDLE.
- Push: a word is written when x_valid && x_ready at a rising edge. x_ready = !full and is registered from FIFO occupancy. A pop in the same cycle does not raise ready until the next cycle.
- Period counter:
  - While enable=1: increments each cycle. When count >= rate_div: internal tick=1 and count reloads to 0.
  - While enable=0: count forced to 0, no ticks.
  - First tick occurs rate_div+1 cycles after enable rises. A rate_div change takes effect at the next compare.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, tick=1 (edge E0):
  - Per channel: if FIFO non-empty, pop the head into the held sample; else reuse the held sample and pulse x_underrun.
  - Load a 16-bit frame: {4'b0000, sample[11:0]}.
  - Enter SHIFT: CS=0, SCLK=1, DIN = frame bit 15.
- SHIFT: each bit occupies 2 cycles.
  - Odd edge: SCLK=0. This falling edge is where the DAC captures.
  - Even edge: SCLK=1 and DIN advances to the next bit, MSB first.
  - Fall k occurs at E(2k-1); fall 16 occurs at E31.
  - At E32: CS=1, SCLK=1, DIN=0, enter GAP. CS is low for exactly 32 cycles.
- GAP: 2 cycles with CS high (E32–E34), then IDLE at E34. Minimum accepted period is 35 cycles, i.e. rate_div=34.
- busy = (state != IDLE).
- Tick while busy: dropped, tick_miss=1 for 1 cycle, no pop, counter continues normally.
- Push and tick in the same cycle with FIFO empty: no pop, underrun pulses, the pushed word is stored for the next tick.
- enable falling mid-frame: the current frame and GAP complete unchanged; no further ticks.
- DINA and DINB are always framed together; channels never transmit independently.

Optional Feature:
DA2_POWERDOWN_EN.
- Defined: adds input pd_mode[1:0]. It is sampled at frame load (E0) and sent as frame bits 13:12; the frame becomes {2'b00, pd_mode, sample}. pd_mode is applied identically to both channels.
- Undefined: no pd_mode port; bits 15:12 are always 0000 (normal operation).

Test Plan:
- Reset then idle: HRESETn low mid-frame -> CS=1, SCLK=1, DIN=0, a_ready=b_ready=1 within the same cycle. After release: no SCLK activity while enable=0.
- Single pair: push A=0xABC, B=0x123, rate_div=99, enable=1 -> CS low on cycle 100 for 32 cycles, 16 falling SCLK edges. DINA bits = 0000_1010_1011_1100, DINB bits = 0000_0001_0010_0011.
- Underrun hold: after the previous test, no further pushes -> next tick re-sends 0xABC/0x123, a_underrun and b_underrun each pulse once.
- FIFO full: push 5 words to A without ticks -> a_ready=0 after the 4th accept, 5th held off. The next tick pops, and a_ready returns 1 one cycle later.
- Overrun: rate_div=20 -> frames every 42 cycles (every second tick accepted), tick_miss pulses once per frame, CS high ≥2 cycles between frames.
- Minimum rate: rate_div=34 -> back-to-back frames, period exactly 35 cycles, tick_miss never asserts.
